// File: rtl/mips_cpu_cache_pkg.sv
// Shared types for the MIPS CPU cache slice.
//   arb_state_t : memory arbiter FSM states.
//   WORD_BYTES  : bytes per bus word.
package mips_cpu_cache_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_WRITE,
    ARB_READ,
    ARB_DONE
  } arb_state_t;

  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/mips_cpu_cache_mem_arbiter.sv
// Shares one Avalon-MM master between write-buffer drain writes and cache
// read-miss line refills. Arbitration happens only in IDLE, so every bus
// transaction is preceded by one idle cycle.
//   clk, rst            : clock, synchronous active-high reset
//   wb_*                : write buffer head word / flags; wb_active and
//                         wb_waitrequest pace the write buffer
//   rd_req/rd_addr/...  : refill request (level) and miss address
//   rd_data/_valid/_idx : refill words streamed back to the cache
//   rd_done             : one-cycle pulse after the last refill word
//   avm_*               : Avalon-MM master port
module mips_cpu_cache_mem_arbiter
  import mips_cpu_cache_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int CNT_BITS   = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wb_write,
  input  logic [31:0]         wb_addr,
  input  logic [31:0]         wb_writedata,
  input  logic [3:0]          wb_byteenable,
  input  logic                wb_empty,
  output logic                wb_active,
  output logic                wb_waitrequest,
  input  logic                rd_req,
  input  logic [31:0]         rd_addr,
  input  logic                rd_addr_in_wb,
  output logic [31:0]         rd_data,
  output logic                rd_data_valid,
  output logic [CNT_BITS-1:0] rd_word_idx,
  output logic                rd_done,
  output logic [31:0]         avm_address,
  output logic                avm_read,
  output logic                avm_write,
  output logic [31:0]         avm_writedata,
  output logic [3:0]          avm_byteenable,
  input  logic                avm_waitrequest,
  input  logic [31:0]         avm_readdata
);

  // Byte-offset bits inside one line; cleared to form the line base.
  localparam logic [31:0]         LINE_MASK = 32'(LINE_WORDS * WORD_BYTES - 1);
  localparam logic [CNT_BITS-1:0] LAST_IDX  = CNT_BITS'(LINE_WORDS - 1);

  arb_state_t          state, state_nxt;
  logic [CNT_BITS-1:0] cnt;
  logic [31:0]         rd_addr_q;
  logic                rd_pending;     // refill accepted and not yet finished
  logic                last_was_read;  // forces a write between back-to-back refills
  logic                rd_beat;

  assign rd_beat = (state == ARB_READ) && !avm_waitrequest;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ARB_IDLE;
      cnt           <= '0;
      rd_addr_q     <= '0;
      rd_pending    <= 1'b0;
      last_was_read <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ARB_IDLE && state_nxt == ARB_READ) begin
        rd_addr_q  <= rd_addr;
        rd_pending <= 1'b1;
      end
      if (state == ARB_IDLE && state_nxt == ARB_WRITE)
        last_was_read <= 1'b0;
      if (state == ARB_READ && state_nxt == ARB_DONE) begin
        last_was_read <= 1'b1;
        rd_pending    <= 1'b0;
      end
      // Explicit clear on the last word keeps non-power-of-2 wrap impossible
      // and leaves the counter at 0 for the next refill.
      if (rd_beat)
        cnt <= (cnt == LAST_IDX) ? '0 : cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt      = state;
    avm_read       = 1'b0;
    avm_write      = 1'b0;
    avm_address    = '0;
    avm_writedata  = '0;
    avm_byteenable = '0;
    wb_active      = 1'b0;
    wb_waitrequest = 1'b1;
    rd_data        = avm_readdata;
    rd_data_valid  = 1'b0;
    rd_word_idx    = cnt;
    rd_done        = 1'b0;
    case (state)
      ARB_IDLE: begin
        // A miss that hits a pending write drains the buffer first; otherwise a
        // read wins unless the previous grant was also a read and writes wait.
        if (rd_req && rd_addr_in_wb && !wb_empty)
          state_nxt = ARB_WRITE;
        else if (rd_req && !rd_addr_in_wb && !(last_was_read && !wb_empty))
          state_nxt = ARB_READ;
        else if (!wb_empty)
          state_nxt = ARB_WRITE;
      end
      ARB_WRITE: begin
        // wb_empty lags the retire edge by a cycle, so exit on wb_write only.
        wb_active      = 1'b1;
        avm_write      = wb_write;
        avm_address    = wb_addr;
        avm_writedata  = wb_writedata;
        avm_byteenable = wb_byteenable;
        wb_waitrequest = avm_waitrequest;
        if (!wb_write || !avm_waitrequest)
          state_nxt = ARB_IDLE;
      end
      ARB_READ: begin
        avm_read       = rd_pending;
        avm_byteenable = 4'hF;
        avm_address    = (rd_addr_q & ~LINE_MASK) | 32'({cnt, 2'b00});
        rd_data_valid  = !avm_waitrequest;
        if (!avm_waitrequest && cnt == LAST_IDX)
          state_nxt = ARB_DONE;
      end
      ARB_DONE: begin
        rd_done   = 1'b1;
        state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

endmodule
